mips16_lsu: RTL and testbench

Load/store unit between the mips_16 core's data port and a variable-latency data memory. Stores are posted into a small write buffer so the core does not stall on them. Loads stall the core until data returns. Memory-side transfers use a req/ready handshake; the single-cycle `mem_read`/`mem_write` pulses of the core become multi-cycle bus transactions.

---
 rtl/mips16_lsu_pkg.sv | 28 ++
 rtl/lsu_store_buffer.sv | 94 +++++++++
 rtl/mips16_lsu.sv | 158 +++++++++++++++
 tb/tb_mips16_lsu.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips16_lsu_pkg.sv
//------------------------------------------------------------------------------
// Module   : mips16_lsu_pkg
// Brief    : Shared FSM states, default sizes and write-buffer entry type.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips16_lsu_pkg;

  localparam int unsigned LSU_AW       = 16;
  localparam int unsigned LSU_DW       = 16;
  localparam int unsigned LSU_WB_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD      = 2'd2,
    ST_RD_DONE = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic [LSU_AW-1:0] addr;
    logic [LSU_DW-1:0] data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/lsu_store_buffer.sv
//------------------------------------------------------------------------------
// Module   : lsu_store_buffer
// Brief    : Posted-store FIFO of {addr, data}; youngest-match lookup port
//            present only when LSU_STORE_FWD_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_store_buffer
  import mips16_lsu_pkg::*;
#(
  parameter int unsigned AW    = LSU_AW,
  parameter int unsigned DW    = LSU_DW,
  parameter int unsigned DEPTH = LSU_WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [AW-1:0]            push_addr_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [AW-1:0]            head_addr_o,
  output logic [DW-1:0]            head_data_o
`ifdef LSU_STORE_FWD_EN
  ,
  input  logic [AW-1:0]            lookup_addr_i,
  output logic                     lookup_hit_o,
  output logic [DW-1:0]            lookup_data_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = DEPTH[PW:0];

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW:0]   count_q;

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign full_o      = (count_q == DEPTH_CNT);
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

`ifdef LSU_STORE_FWD_EN
  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    lookup_hit_o  = 1'b0;
    lookup_data_o = '0;
    idx           = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + i[PW-1:0];
      if ((i < 32'(count_q)) && (addr_q[idx] == lookup_addr_i)) begin
        lookup_hit_o  = 1'b1;
        lookup_data_o = data_q[idx];
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mips16_lsu.sv
//------------------------------------------------------------------------------
// Module   : mips16_lsu
// Brief    : mips_16 load/store unit: posted stores, stalling loads, req/ready
//            memory port. Store-to-load forwarding when LSU_STORE_FWD_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips16_lsu
  import mips16_lsu_pkg::*;
#(
  parameter int unsigned AW       = LSU_AW,
  parameter int unsigned DW       = LSU_DW,
  parameter int unsigned WB_DEPTH = LSU_WB_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [AW-1:0]               cpu_addr,
  input  logic [DW-1:0]               cpu_wdata,
  input  logic                        cpu_read,
  input  logic                        cpu_write,
  output logic [DW-1:0]               cpu_rdata,
  output logic                        cpu_stall,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [AW-1:0]               mem_addr,
  output logic [DW-1:0]               mem_wdata,
  input  logic                        mem_ready,
  input  logic [DW-1:0]               mem_rdata,
  output logic [$clog2(WB_DEPTH):0]   wb_count
);

  lsu_state_e    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          wb_full, wb_empty, wb_push, wb_pop;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          rd_req, fwd_hit, load_done;
  logic [DW-1:0] fwd_data;

  // A simultaneous read and write is handled as a store.
  assign rd_req  = cpu_read & ~cpu_write;
  assign wb_push = cpu_write & ~wb_full;

`ifdef LSU_STORE_FWD_EN
  logic lookup_hit;
`endif

  lsu_store_buffer #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (WB_DEPTH)
  ) u_store_buffer (
    .clk           (clk),
    .reset_n       (reset_n),
    .push_i        (wb_push),
    .push_addr_i   (cpu_addr),
    .push_data_i   (cpu_wdata),
    .pop_i         (wb_pop),
    .full_o        (wb_full),
    .empty_o       (wb_empty),
    .count_o       (wb_count),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data)
`ifdef LSU_STORE_FWD_EN
    ,
    .lookup_addr_i (cpu_addr),
    .lookup_hit_o  (lookup_hit),
    .lookup_data_o (fwd_data)
`endif
  );

`ifdef LSU_STORE_FWD_EN
  assign fwd_hit = rd_req & lookup_hit;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    wb_pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Draining stores first keeps a later load behind earlier stores.
        if (!wb_empty) begin
          state_d     = ST_WR;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = head_addr;
          mem_wdata_d = head_data;
        end else if (rd_req && !fwd_hit) begin
          state_d    = ST_RD;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = cpu_addr;
        end
      end
      ST_WR: begin
        if (mem_ready) begin
          wb_pop    = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_RD: begin
        if (mem_ready) begin
          rdata_d   = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = ST_RD_DONE;
        end
      end
      ST_RD_DONE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign load_done = (state_q == ST_RD_DONE) | fwd_hit;
  assign cpu_stall = (cpu_write & wb_full) | (rd_req & ~load_done);
  assign cpu_rdata = (state_q == ST_RD_DONE) ? rdata_q :
                     fwd_hit                 ? fwd_data : rdata_q;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mips16_lsu.sv
//------------------------------------------------------------------------------
// Module   : tb_mips16_lsu
// Brief    : Self-checking bench for mips16_lsu against an architectural
//            memory model and an in-order store scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips16_lsu;
  import mips16_lsu_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int WB = 4;

  typedef enum {OP_NONE, OP_ST, OP_LD} op_e;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_read, cpu_write;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic [2:0]    wb_count;

  always #5 clk = ~clk;

  mips16_lsu #(.AW(AW), .DW(DW), .WB_DEPTH(WB)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .wb_count(wb_count)
  );

  always @(posedge clk)
    if (reset_n) assert (!(cpu_read && cpu_write)) else $error("illegal cpu_read with cpu_write");

  int             n_checks = 0;
  int             n_errors = 0;
  logic [15:0]    mem_arr  [256];
  logic [15:0]    arch_mem [256];
  wb_entry_t      exp_wq [$];
  op_e            cur_op = OP_NONE;
  int             ready_prob = 100;
  int             low_cnt = 0;
  logic           hold_v = 1'b0;
  logic [33:0]    hold_val;
  int             n_rd = 0;
  int             n_wr = 0;
  logic [15:0]    last_ld = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: memory-side response, scoreboard, then retire the core op.
  task automatic tick(output logic stalled);
    logic      rdy;
    wb_entry_t e;
    @(negedge clk);
    rdy = ($urandom_range(99) < ready_prob);
    if (low_cnt > 0 && mem_req) begin
      rdy = 1'b0;
      low_cnt--;
    end
    mem_ready = rdy;
    mem_rdata = rdy ? mem_arr[mem_addr[7:0]] : 16'($urandom);
    #1;
    check_eq("wb_count", wb_count, exp_wq.size());
    if (cur_op == OP_ST)   check_eq("st_stall", cpu_stall, exp_wq.size() == WB);
    if (cur_op == OP_NONE) check_eq("idle_stall", cpu_stall, 0);
    if (hold_v) check_eq("bus_hold", {mem_req, mem_we, mem_addr, mem_wdata}, hold_val);
    hold_v   = mem_req && !mem_ready;
    hold_val = {mem_req, mem_we, mem_addr, mem_wdata};
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        if (exp_wq.size() == 0) check_eq("spurious_wr", 1, 0);
        else begin
          e = exp_wq.pop_front();
          check_eq("wr_addr", mem_addr, e.addr);
          check_eq("wr_data", mem_wdata, e.data);
        end
        mem_arr[mem_addr[7:0]] = mem_wdata;
        n_wr++;
      end else begin
        check_eq("rd_behind_st", exp_wq.size(), 0);
        n_rd++;
      end
    end
    stalled = cpu_stall;
    if (!cpu_stall) begin
      if (cur_op == OP_ST) begin
        arch_mem[cpu_addr[7:0]] = cpu_wdata;
        e.addr = cpu_addr;
        e.data = cpu_wdata;
        exp_wq.push_back(e);
      end else if (cur_op == OP_LD) begin
        check_eq("ld_data", cpu_rdata, arch_mem[cpu_addr[7:0]]);
        last_ld = cpu_rdata;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input op_e op, input logic [15:0] a, input logic [15:0] d, output int stalls);
    logic st;
    cur_op    = op;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_read  = (op == OP_LD);
    cpu_write = (op == OP_ST);
    stalls    = 0;
    st        = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick(st);
      if (!st) break;
      stalls++;
    end
    if (st) check_eq("op_timeout", st, 0);
    cur_op    = OP_NONE;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic drain();
    logic st;
    int   k;
    for (k = 0; k < 200; k++) begin
      if (exp_wq.size() == 0 && !mem_req) break;
      tick(st);
    end
    if (k == 200) check_eq("drain_timeout", exp_wq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s, rd0, wr0, r, bad;
    logic        st;
    logic [15:0] a;

    reset_n = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i]  = 16'($urandom);
      arch_mem[i] = mem_arr[i];
    end
    repeat (2) @(negedge clk);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_cpu_rdata", cpu_rdata, 0);
    check_eq("rst_wb_count", wb_count, 0);
    check_eq("rst_cpu_stall", cpu_stall, 0);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Store burst with an always-ready memory: no stalls, writes in order.
    ready_prob = 100;
    wr0 = n_wr;
    for (int i = 0; i < 4; i++) begin
      run_op(OP_ST, 16'h0010 + 16'(2 * i), 16'h00A0 + 16'(i), s);
      check_eq("burst_stall", s, 0);
    end
    drain();
    check_eq("burst_writes", n_wr - wr0, 4);

    // Fill the buffer against a stalled memory, then a fifth store.
    ready_prob = 0;
    for (int i = 0; i < 4; i++) begin
      run_op(OP_ST, 16'h0010 + 16'(2 * i), 16'h00B0 + 16'(i), s);
      check_eq("fill_stall", s, 0);
    end
    cur_op = OP_ST; cpu_addr = 16'h0018; cpu_wdata = 16'h00B4; cpu_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(st);
      check_eq("full_stall", st, 1);
    end
    ready_prob = 100;
    tick(st);
    check_eq("pop_cycle_stall", st, 1);
    ready_prob = 0;
    tick(st);
    check_eq("after_pop_stall", st, 0);
    cur_op = OP_NONE; cpu_write = 1'b0;
    ready_prob = 100;
    drain();

    // Load directly behind a store to the same address.
    run_op(OP_ST, 16'h0020, 16'h1234, s);
    run_op(OP_LD, 16'h0020, 16'h0000, s);
    check_eq("order_rdata", last_ld, 16'h1234);
`ifdef LSU_STORE_FWD_EN
    check_eq("order_stall", s, 0);
`else
    check_eq("order_stall", s, 4);
`endif
    drain();

    // Two buffered stores to one address, then a load of it.
    ready_prob = 0;
    run_op(OP_ST, 16'h0030, 16'h1111, s);
    run_op(OP_ST, 16'h0030, 16'h2222, s);
    rd0 = n_rd;
`ifdef LSU_STORE_FWD_EN
    run_op(OP_LD, 16'h0030, 16'h0000, s);
    check_eq("fwd_stall", s, 0);
    check_eq("fwd_no_read", n_rd - rd0, 0);
`else
    ready_prob = 100;
    run_op(OP_LD, 16'h0030, 16'h0000, s);
`endif
    check_eq("fwd_rdata", last_ld, 16'h2222);
    ready_prob = 100;
    drain();

    // Read with three wait states.
    mem_arr[8'h40]  = 16'hBEEF;
    arch_mem[8'h40] = 16'hBEEF;
    low_cnt = 3;
    run_op(OP_LD, 16'h0040, 16'h0000, s);
    check_eq("ws_stall", s, 5);
    check_eq("ws_rdata", last_ld, 16'hBEEF);

    // Asynchronous reset while a drain is in progress.
    ready_prob = 0;
    run_op(OP_ST, 16'h0050, 16'h5555, s);
    run_op(OP_ST, 16'h0052, 16'h5656, s);
    check_eq("pre_rst_req", mem_req, 1);
    check_eq("pre_rst_count", wb_count, 2);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_req", mem_req, 0);
    check_eq("mid_rst_count", wb_count, 0);
    check_eq("mid_rst_rdata", cpu_rdata, 0);
    exp_wq.delete();
    hold_v = 1'b0;
    for (int i = 0; i < 256; i++) arch_mem[i] = mem_arr[i];
    @(negedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    ready_prob = 100;
    rd0 = n_rd;
    run_op(OP_LD, 16'h0050, 16'h0000, s);
    check_eq("post_rst_stall", s, 2);
    check_eq("post_rst_read", n_rd - rd0, 1);
    check_eq("post_rst_rdata", last_ld, mem_arr[8'h50]);

    // Random mix of stores, loads and idle cycles over a small address window.
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) ready_prob = $urandom_range(30, 100);
      r = $urandom_range(99);
      a = 16'h0080 + 16'($urandom_range(0, 7));
      if (r < 45)      run_op(OP_ST, a, 16'($urandom), s);
      else if (r < 90) run_op(OP_LD, a, 16'h0000, s);
      else             run_op(OP_NONE, a, 16'h0000, s);
    end
    ready_prob = 100;
    drain();
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem_arr[i] !== arch_mem[i]) bad++;
    check_eq("final_mem", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
